// File: rtl/pwr_switch_ack_model.sv
// pwr_switch_ack_model
// Behavioural-accurate model of a bank of power-switch acknowledge paths.
// Each channel mirrors its switch request on ack after a programmable rise or
// fall latency. A request that reverts before its latency elapses aborts the
// transition. hold freezes every in-flight latency counter.
//
// Ports
//   clk_i      : clock; all state updates on the rising edge
//   rst_i      : asynchronous active-high reset
//   sw_req_i   : per-channel switch request level
//   hold_i     : freezes all latency counters while high
//   ack_o      : per-channel delayed acknowledge (registered)
//   pending_o  : channel has a transition in flight
//   busy_o     : OR of pending_o
//   done_o     : one-cycle pulse when ack_o of a channel changes
//   glitch_o   : one-cycle pulse when an in-flight transition is aborted
module pwr_switch_ack_model #(
    parameter int unsigned        NUM_CH   = 4,
    parameter int unsigned        RISE_LAT = 15,
    parameter int unsigned        FALL_LAT = 15,
    parameter logic [NUM_CH-1:0]  RST_VAL  = '1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] sw_req_i,
    input  logic              hold_i,
    output logic [NUM_CH-1:0] ack_o,
    output logic [NUM_CH-1:0] pending_o,
    output logic              busy_o,
    output logic [NUM_CH-1:0] done_o,
    output logic [NUM_CH-1:0] glitch_o
);

    localparam int unsigned MAX_LAT = (RISE_LAT > FALL_LAT) ? RISE_LAT : FALL_LAT;
    // A latency of 1 needs only the value 0; keep at least one counter bit.
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // Reject unsupported configurations at elaboration.
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("pwr_switch_ack_model: NUM_CH must be in 1..32");
    end
    if (RISE_LAT == 0) begin : g_bad_rise
        $error("pwr_switch_ack_model: RISE_LAT must be >= 1");
    end
    if (FALL_LAT == 0) begin : g_bad_fall
        $error("pwr_switch_ack_model: FALL_LAT must be >= 1");
    end

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] ack_q;
    logic [NUM_CH-1:0] ack_d;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] done_d;
    logic [NUM_CH-1:0] glitch_q;
    logic [NUM_CH-1:0] glitch_d;

    // State, counter and output registers for all channels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= STABLE;
                cnt_q[c]   <= '0;
            end
            ack_q    <= RST_VAL;
            done_q   <= '0;
            glitch_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            ack_q    <= ack_d;
            done_q   <= done_d;
            glitch_q <= glitch_d;
        end
    end

    // Per-channel next-state logic; channels never look at each other.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            cnt_d[c]    = cnt_q[c];
            ack_d[c]    = ack_q[c];
            done_d[c]   = 1'b0;
            glitch_d[c] = 1'b0;

            case (state_q[c])
                STABLE: begin
                    // Loads happen even under hold; only counting is frozen.
                    if (sw_req_i[c] != ack_q[c]) begin
                        state_d[c] = PENDING;
                        cnt_d[c]   = sw_req_i[c] ? CNT_W'(RISE_LAT - 1)
                                                 : CNT_W'(FALL_LAT - 1);
                    end
                end
                PENDING: begin
                    if (sw_req_i[c] == ack_q[c]) begin
                        // Abort wins over completion and over hold; no partial
                        // count survives into the next transition.
                        state_d[c]  = STABLE;
                        cnt_d[c]    = '0;
                        glitch_d[c] = 1'b1;
                    end else if (!hold_i) begin
                        if (cnt_q[c] == '0) begin
                            state_d[c] = STABLE;
                            ack_d[c]   = sw_req_i[c];
                            done_d[c]  = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[c] = STABLE;
                    cnt_d[c]   = '0;
                end
            endcase
        end
    end

    // Pending flags come straight from the state registers.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pending_o[c] = (state_q[c] == PENDING);
        end
    end

    assign busy_o   = |pending_o;
    assign ack_o    = ack_q;
    assign done_o   = done_q;
    assign glitch_o = glitch_q;

endmodule

// File: doc/pwr_switch_ack_model.md
PWR_SWITCH_ACK_MODEL -- requirements
Module: pwr_switch_ack_model

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent power-switch channels (1..32).
REQ-002 SHALL have parameter RISE_LAT, default 15: cycles from a sustained ack 0->1 request to ack update (>=1).
REQ-003 SHALL have parameter FALL_LAT, default 15: cycles from a sustained ack 1->0 request to ack update (>=1).
REQ-004 SHALL have parameter RST_VAL, default all ones, NUM_CH bits: ack_o value during and after reset.
REQ-005 SHALL fail elaboration if RISE_LAT or FALL_LAT is 0 or NUM_CH is outside 1..32.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all state is updated on its rising edge.
REQ-007 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port sw_req_i, input, NUM_CH: per-channel switch request level, from the power controller.
REQ-009 SHALL have port hold_i, input, 1: freezes all latency counters while high.
REQ-010 SHALL have port ack_o, output, NUM_CH: per-channel delayed switch acknowledge, registered.
REQ-011 SHALL have port pending_o, output, NUM_CH: channel has a transition in flight.
REQ-012 SHALL have port busy_o, output, 1: OR of pending_o.
REQ-013 SHALL have port done_o, output, NUM_CH: one-cycle pulse when ack_o of that channel changes.
REQ-014 SHALL have port glitch_o, output, NUM_CH: one-cycle pulse when an in-flight transition is aborted.

Function
REQ-015 SHALL implement one independent two-state FSM per channel: STABLE and PENDING, plus a down-counter of width clog2(max(RISE_LAT,FALL_LAT)).
REQ-016 In STABLE, at an edge where sw_req_i[c] != ack_o[c], SHALL move to PENDING and load the counter with RISE_LAT-1 if sw_req_i[c]=1, else FALL_LAT-1.
REQ-017 In PENDING with hold_i=0, counter != 0 and sw_req_i[c] != ack_o[c], SHALL decrement the counter by one.
REQ-018 In PENDING with hold_i=0, counter == 0 and sw_req_i[c] != ack_o[c], SHALL set ack_o[c] <= sw_req_i[c], return to STABLE and pulse done_o[c] in the following cycle.
REQ-019 Net latency: request first sampled differing at edge t and held => ack_o changes at edge t+LAT (LAT = RISE_LAT or FALL_LAT), absent hold_i.
REQ-020 In PENDING, at any edge where sw_req_i[c] == ack_o[c] (regardless of hold_i or counter), SHALL return to STABLE without changing ack_o[c] and pulse glitch_o[c]; abort takes priority over completion.
REQ-021 After an abort, a new difference SHALL restart the full latency; no partial count is retained.
REQ-022 While hold_i=1, counters SHALL hold and no completion SHALL occur; each cycle of hold_i extends latency by exactly one cycle; new STABLE->PENDING loads still occur.
REQ-023 pending_o[c] SHALL be 1 exactly while channel c is in PENDING; busy_o SHALL be combinational OR of pending_o.
REQ-024 done_o and glitch_o SHALL be registered, never high together on one channel, and never high for two consecutive cycles from one transition.
REQ-025 Channels SHALL not interact; simultaneous requests on all channels complete in the same cycle if latencies match.

Reset
REQ-026 While rst_i=1: ack_o=RST_VAL, all FSMs STABLE, counters 0, pending_o=0, busy_o=0, done_o=0, glitch_o=0.
REQ-027 Reset asserted mid-transition SHALL discard the transition; after release, channels whose sw_req_i differs from RST_VAL start a fresh full-latency transition at the first edge.

Verification
REQ-028 Defaults, rst_i released, sw_req_i=4'hF held -> no pending, ack_o stays 4'hF, no pulses for 100 cycles.
REQ-029 sw_req_i[0] 1->0 sampled at edge t, held -> pending_o[0]=1 edges t..t+14, ack_o[0]=0 and done_o[0]=1 after edge t+15, busy_o=0 after.
REQ-030 RISE_LAT=3, FALL_LAT=8: ch1 0->1 and ch2 1->0 at same edge t -> ack_o[1] changes at t+3, ack_o[2] at t+8, each with its own done pulse.
REQ-031 sw_req_i[3] dropped 5 cycles then restored -> glitch_o[3] single pulse, ack_o[3] unchanged, no done_o[3]; re-drop -> full 15-cycle latency again.
REQ-032 hold_i=1 for 4 cycles during a 15-cycle transition -> ack_o updates at t+19; hold_i high at counter 0 -> no update until release.
REQ-033 rst_i pulsed at t+7 of a 15-cycle transition -> ack_o=RST_VAL immediately, pending cleared asynchronously; request still low -> new transition completes 15 cycles after release.
